// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - ALU opcodes as seen on ctrl_i
//   - 2-bit operation codes understood by the 1-bit slice
//   - FSM state encodings (plain localparam constants)
//   - slice control bundle and the opcode -> slice control decoder
package alu_serial_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SLICE_AND  = 2'b00;
  localparam logic [1:0] SLICE_OR   = 2'b01;
  localparam logic [1:0] SLICE_SUM  = 2'b10;
  localparam logic [1:0] SLICE_LESS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
  } slice_ctrl_t;

  // Illegal opcodes fall back to a plain AND; the sequencer forces their
  // outputs to zero, so the slice setting only needs to be harmless.
  function automatic slice_ctrl_t decode_ctrl(input logic [3:0] ctrl);
    slice_ctrl_t sc;
    case (ctrl)
      ALU_AND:          sc = {1'b0, 1'b0, SLICE_AND};
      ALU_OR:           sc = {1'b0, 1'b0, SLICE_OR};
      ALU_ADD:          sc = {1'b0, 1'b0, SLICE_SUM};
      ALU_SUB, ALU_SLT: sc = {1'b0, 1'b1, SLICE_SUM};
      ALU_NOR:          sc = {1'b1, 1'b1, SLICE_AND};
      default:          sc = {1'b0, 1'b0, SLICE_AND};
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// alu_slice_1b: combinational 1-bit ALU slice.
// Ports:
//   src1, src2          operand bits
//   less                value passed through for the LESS operation
//   A_invert, B_invert  invert the corresponding operand bit before use
//   cin                 carry in
//   operation[1:0]      00 AND, 01 OR, 10 SUM, 11 LESS
//   result, cout        slice result bit and full-adder carry out
module alu_slice_1b
  import alu_serial_ctrl_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);

  logic a;
  logic b;

  assign a    = src1 ^ A_invert;
  assign b    = src2 ^ B_invert;
  assign cout = (a & b) | (a & cin) | (b & cin);

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path can leave it unassigned and infer a latch.
  always_comb begin
    result = 1'b0;
    case (operation)
      SLICE_AND:  result = a & b;
      SLICE_OR:   result = a | b;
      SLICE_SUM:  result = a ^ b ^ cin;
      SLICE_LESS: result = less;
      default:    result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer. One 1-bit slice is stepped over
// WIDTH cycles, LSB first, with its carry fed back through a flop.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               request, accepted only in IDLE
//   src1_i, src2_i        operands, latched on acceptance
//   ctrl_i                ALU opcode, latched on acceptance
//   busy_o                high in RUN and DONE
//   done_o                one-cycle pulse, result outputs valid
//   result_o, zero_o      result and result==0, held until the next DONE
//   cout_o, overflow_o    final carry / signed overflow (ADD/SUB only)
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  // The MSB never lands here: it is taken straight from the slice when the
  // final result is assembled.
  logic [WIDTH-2:0] shreg;

  slice_ctrl_t      sc_run;
  slice_ctrl_t      sc_new;
  logic             s_result;
  logic             s_cout;
  logic             last_bit;
  logic             accept;
  logic             msb_ovf;
  logic [WIDTH-1:0] raw_vec;
  logic [WIDTH-1:0] fin_result;
  logic             fin_cout;
  logic             fin_ovf;

  assign sc_run   = decode_ctrl(ctrl_q);
  assign sc_new   = decode_ctrl(ctrl_i);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = (state == ST_IDLE) && start_i;

  alu_slice_1b u_slice (
    .src1      (a_q[cnt]),
    .src2      (b_q[cnt]),
    .less      (1'b0),
    .A_invert  (sc_run.a_inv),
    .B_invert  (sc_run.b_inv),
    .cin       (carry),
    .operation (sc_run.op),
    .result    (s_result),
    .cout      (s_cout)
  );

  // Evaluated during the last RUN cycle, while the slice is on the MSB.
  assign raw_vec = {s_result, shreg};
  assign msb_ovf = carry ^ s_cout;

  always_comb begin
    fin_result = '0;
    fin_cout   = 1'b0;
    fin_ovf    = 1'b0;
    case (ctrl_q)
      ALU_AND, ALU_OR, ALU_NOR: fin_result = raw_vec;
      ALU_ADD, ALU_SUB: begin
        fin_result = raw_vec;
        fin_cout   = s_cout;
        fin_ovf    = msb_ovf;
      end
      // Sign of the true difference: MSB of the wrapped sum, corrected by overflow.
      ALU_SLT: fin_result = {{(WIDTH-1){1'b0}}, s_result ^ msb_ovf};
      default: ;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cnt   <= '0;
            carry <= sc_new.b_inv;  // +1 of the two's-complement negate
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry <= s_cout;
          if (last_bit) begin
            result_o   <= fin_result;
            zero_o     <= (fin_result == '0);
            cout_o     <= fin_cout;
            overflow_o <= fin_ovf;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: operand latches and the shift register carry no reset: each run
  // reloads the operands and rewrites every shift-register bit before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q    <= src1_i;
      b_q    <= src2_i;
      ctrl_q <= ctrl_i;
    end
    if (state == ST_RUN && !last_bit) begin
      shreg[cnt] <= s_result;
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=32). A cycle-level reference
// model computes results with ordinary arithmetic; one compare process checks
// every DUT output against it each cycle, and directed tests add hand-computed
// literal expectations.
module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  alu_serial_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .src1_i     (src1),
    .src2_i     (src2),
    .ctrl_i     (ctrl),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .zero_o     (zero),
    .cout_o     (cout),
    .overflow_o (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {cout, overflow, result}.
  function automatic logic [33:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: ;
    endcase
    return {c, v, r};
  endfunction

  // m_phase: 0 idle, 1..WIDTH running, WIDTH+1 done cycle.
  int          m_phase;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [3:0]  m_op;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_cout;
  logic        m_ovf;
  logic [33:0] m_calc;

  assign m_calc = model_alu(m_a, m_b, m_op);

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
      m_zero  <= 1'b1;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     <= src1;
        m_b     <= src2;
        m_op    <= ctrl;
        m_phase <= 1;
      end
    end else if (m_phase == WIDTH) begin
      m_phase <= WIDTH + 1;
      m_res   <= m_calc[31:0];
      m_zero  <= (m_calc[31:0] == 32'd0);
      m_cout  <= m_calc[33];
      m_ovf   <= m_calc[32];
    end else if (m_phase == WIDTH + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",     busy,   m_phase != 0);
      check("done",     done,   m_phase == WIDTH + 1);
      check("result",   result, m_res);
      check("zero",     zero,   m_zero);
      check("cout",     cout,   m_cout);
      check("overflow", ovf,    m_ovf);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    start = 1'b1;
    src1  = a;
    src2  = b;
    ctrl  = op;
  endtask

  // Called right after start is driven; counts negedges until done_o.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp_res,
                        input logic exp_cout, input logic exp_ovf, input logic exp_zero);
    int lat;
    @(negedge clk);
    start_op(a, b, op);
    wait_done(lat);
    check({name, "_latency"}, lat, 33);
    check({name, "_result"},  result, exp_res);
    check({name, "_cout"},    cout, exp_cout);
    check({name, "_ovf"},     ovf, exp_ovf);
    check({name, "_zero"},    zero, exp_zero);
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    ctrl  = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_result", result, 0);
    check("rst_zero",   zero,   1);
    check("rst_cout",   cout,   0);
    check("rst_ovf",    ovf,    0);
    rst = 1'b0;

    run_op("add_5_3",   32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008, 0, 0, 0);
    run_op("sub_ovf",   32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_SUB, 32'h8000_0000, 0, 1, 0);
    run_op("sub_5_5",   32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 1, 0, 1);
    run_op("slt_neg",   32'hFFFF_FFFD, 32'h0000_0002, OP_SLT, 32'h0000_0001, 0, 0, 0);
    run_op("slt_ovf",   32'h7FFF_FFFF, 32'h8000_0000, OP_SLT, 32'h0000_0000, 0, 0, 1);
    run_op("and",       32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 32'hF000_F000, 0, 0, 0);
    run_op("or",        32'hF0F0_F0F0, 32'hFF00_FF00, OP_OR,  32'hFFF0_FFF0, 0, 0, 0);
    run_op("nor",       32'hF0F0_F0F0, 32'hFF00_FF00, OP_NOR, 32'h000F_000F, 0, 0, 0);
    run_op("illegal",   32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_BAD, 32'h0000_0000, 0, 0, 1);
    run_op("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1, 0, 1);

    // Second start and operand changes while busy must be ignored.
    @(negedge clk);
    start_op(32'h0000_0005, 32'h0000_0003, OP_ADD);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        check("midrun_busy", busy, 1);
        start_op(32'h0000_0100, 32'h0000_0007, OP_SUB);
      end
      if (k == 10) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("midrun_latency", lat, 33);
    check("midrun_result",  result, 32'h0000_0008);

    // Back-to-back: start held from the DONE cycle, accepted at the end of
    // the following IDLE cycle.
    @(negedge clk);
    start_op(32'h0000_000A, 32'h0000_0003, OP_SUB);
    wait_done(lat);
    check("b2b_first_result", result, 32'h0000_0007);
    start_op(32'h0000_0001, 32'h0000_0001, OP_ADD);
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    wait_done(lat);
    check("b2b_latency", lat, 33);
    check("b2b_result",  result, 32'h0000_0002);

    // Reset while the slice works on bit 10 of a subtract (carry flop is 1).
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'h0000_0001, OP_SUB);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   busy,   0);
    check("midrst_done",   done,   0);
    check("midrst_result", result, 0);
    check("midrst_zero",   zero,   1);
    check("midrst_cout",   cout,   0);
    check("midrst_ovf",    ovf,    0);
    rst = 1'b0;
    run_op("post_rst_add", 32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
